// File: rtl/audio_mixer_seq.sv
// Time-multiplexed stereo mixer: one shared MAC walks all channels once per
// lrclk half-frame and emits a saturated left or right sample.
module audio_mixer_seq #(
  parameter int CHANNEL_COUNT = 8,
  parameter int SAMPLE_W      = 16,
  parameter int VOLUME_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              lrclk,
  input  logic [CHANNEL_COUNT*SAMPLE_W-1:0] ch_samples,
  input  logic [CHANNEL_COUNT-1:0]          ch_enable,
  input  logic                              cfg_we,
  input  logic [$clog2(CHANNEL_COUNT)-1:0]  cfg_ch,
  input  logic [VOLUME_W-1:0]               cfg_volume,
  input  logic [1:0]                        cfg_pan,
  input  logic                              overrun_clr,
  output logic signed [SAMPLE_W-1:0]        sample_l,
  output logic signed [SAMPLE_W-1:0]        sample_r,
  output logic                              l_valid,
  output logic                              r_valid,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              overrun
);

  localparam int IDX_W  = $clog2(CHANNEL_COUNT);
  localparam int PROD_W = SAMPLE_W + VOLUME_W + 1;
  localparam int ACC_W  = PROD_W + IDX_W;

  localparam logic [VOLUME_W-1:0]     UNITY_VOL = {1'b1, {(VOLUME_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(CHANNEL_COUNT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_MIX, ST_SAT} state_t;

  state_t                    state;
  logic [VOLUME_W-1:0]       volume [CHANNEL_COUNT];
  logic [1:0]                pan    [CHANNEL_COUNT];
  logic                      lrSync1, lrSync2, lrPrev;
  logic                      edgePulse, edgeSide;
  logic                      side;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [SAMPLE_W-1:0] curSample;
  logic [VOLUME_W-1:0]       curVol;
  logic signed [PROD_W-1:0]  product, shifted;
  logic signed [ACC_W-1:0]   term;
  logic signed [SAMPLE_W-1:0] satSample;

  // Bring lrclk into the clk domain and remember the previous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrSync1 <= 1'b0;
      lrSync2 <= 1'b0;
      lrPrev  <= 1'b0;
    end else begin
      lrSync1 <= lrclk;
      lrSync2 <= lrSync1;
      lrPrev  <= lrSync2;
    end
  end

  // Any level change is an edge; a rising edge (new level 1) selects left (side 0)
  assign edgePulse = lrSync2 ^ lrPrev;
  assign edgeSide  = ~lrSync2;
  assign busy      = (state != ST_IDLE);

  // Per-channel volume/pan registers, written by the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        volume[i] <= UNITY_VOL;
        pan[i]    <= 2'b11;
      end
    end else if (cfg_we && (int'(cfg_ch) < CHANNEL_COUNT)) begin
      volume[cfg_ch] <= cfg_volume;
      pan[cfg_ch]    <= cfg_pan;
    end
  end

  // Scaled contribution of the channel currently selected by idx
  always_comb begin
    curSample = ch_samples[int'(idx)*SAMPLE_W +: SAMPLE_W];
    curVol    = volume[idx];
    product   = curSample * $signed({1'b0, curVol});
    shifted   = product >>> (VOLUME_W - 1);
    term      = '0;
    if (ch_enable[idx] && pan[idx][side])
      term = ACC_W'(shifted);
  end

  // Clamp the wide accumulator to the output sample range
  always_comb begin
    satSample = acc[SAMPLE_W-1:0];
    if (acc > SAT_MAX)
      satSample = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (acc < SAT_MIN)
      satSample = {1'b1, {(SAMPLE_W-1){1'b0}}};
  end

  // Mix sequencer: IDLE -> MIX (one channel per cycle) -> SAT -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      side       <= 1'b0;
      idx        <= '0;
      acc        <= '0;
      sample_l   <= '0;
      sample_r   <= '0;
      l_valid    <= 1'b0;
      r_valid    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      l_valid    <= 1'b0;
      r_valid    <= 1'b0;
      frame_done <= 1'b0;
      if (edgePulse && state != ST_IDLE)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (edgePulse) begin
            side  <= edgeSide;
            acc   <= '0;
            idx   <= '0;
            state <= ST_MIX;
          end
        end
        ST_MIX: begin
          acc <= acc + term;
          if (idx == LAST_IDX)
            state <= ST_SAT;
          else
            idx <= idx + 1'b1;
        end
        ST_SAT: begin
          if (side) begin
            sample_r   <= satSample;
            r_valid    <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            sample_l <= satSample;
            l_valid  <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Bench for audio_mixer_seq: directed scenarios plus randomized half-frames
// checked against an arithmetic reference model of the mix.
module tb_audio_mixer_seq;
  localparam int CH = 8;
  localparam int SW = 16;
  localparam int VW = 8;
  localparam int LATENCY = 12;  // 2 synchroniser cycles + edge-to-output (CH+2)

  logic                 clk, rst, lrclk;
  logic [CH*SW-1:0]     ch_samples;
  logic [CH-1:0]        ch_enable;
  logic                 cfg_we;
  logic [2:0]           cfg_ch;
  logic [VW-1:0]        cfg_volume;
  logic [1:0]           cfg_pan;
  logic                 overrun_clr;
  logic signed [SW-1:0] sample_l, sample_r;
  logic                 l_valid, r_valid, frame_done, busy, overrun;

  int       tests = 0;
  int       failed = 0;
  int       sIn  [CH];
  bit       en   [CH];
  int       mVol [CH];
  bit [1:0] mPan [CH];
  int       cycCount, lPulses, rPulses;
  logic signed [SW-1:0] expVal;
  bit       rightSide;

  audio_mixer_seq #(.CHANNEL_COUNT(CH), .SAMPLE_W(SW), .VOLUME_W(VW)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk),
    .ch_samples(ch_samples), .ch_enable(ch_enable),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_volume(cfg_volume), .cfg_pan(cfg_pan),
    .overrun_clr(overrun_clr),
    .sample_l(sample_l), .sample_r(sample_r),
    .l_valid(l_valid), .r_valid(r_valid), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of floor(sample*volume/128) over enabled channels panned to side, then clamp
  function automatic logic signed [SW-1:0] refMix(input bit right);
    longint total = 0;
    longint p;
    for (int i = 0; i < CH; i++) begin
      if (en[i] && mPan[i][right]) begin
        p = longint'(sIn[i]) * longint'(mVol[i]);
        if (p >= 0) total += p / 128;
        else        total -= (-p + 127) / 128;
      end
    end
    if (total > 32767)  total = 32767;
    if (total < -32768) total = -32768;
    return SW'(total);
  endfunction

  task automatic applyInputs();
    for (int i = 0; i < CH; i++) begin
      ch_samples[i*SW +: SW] = SW'(sIn[i]);
      ch_enable[i]           = en[i];
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      mVol[i] = 128;
      mPan[i] = 2'b11;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycCount++;
    if (l_valid) lPulses++;
    if (r_valid) rPulses++;
  endtask

  task automatic doCfg(input int ch, input int vol, input bit [1:0] pn);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_volume = VW'(vol); cfg_pan = pn;
    tick();
    cfg_we = 1'b0;
    mVol[ch] = vol;
    mPan[ch] = pn;
  endtask

  task automatic startEdge();
    @(negedge clk);
    lrclk = ~lrclk;
    cycCount = 0;
    lPulses  = 0;
    rPulses  = 0;
  endtask

  task automatic waitResult(input bit right, input string tag, input logic signed [SW-1:0] exp);
    int budget = 0;
    while (!(right ? r_valid : l_valid) && budget < 40) begin
      tick();
      budget++;
    end
    chk({tag, "_valid"}, right ? r_valid : l_valid, 1);
    chk({tag, "_latency"}, cycCount, LATENCY);
    chk({tag, "_sample"}, right ? sample_r : sample_l, exp);
    chk({tag, "_frame_done"}, frame_done, right);
    repeat (15) tick();
    chk({tag, "_lpulses"}, lPulses, right ? 0 : 1);
    chk({tag, "_rpulses"}, rPulses, right ? 1 : 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic runHalf(input string tag);
    bit right;
    logic signed [SW-1:0] exp;
    right = lrclk;  // current level 1 means the next edge is falling -> right
    exp = refMix(right);
    startEdge();
    waitResult(right, tag, exp);
  endtask

  initial begin
    rst = 1'b1; lrclk = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_volume = '0; cfg_pan = '0;
    overrun_clr = 1'b0; cycCount = 0; lPulses = 0; rPulses = 0;
    for (int i = 0; i < CH; i++) begin sIn[i] = 0; en[i] = 1'b0; end
    modelReset();
    applyInputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);
    chk("rst_l_valid", l_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();

    // Single channel at unity gain
    sIn[0] = 1000; en[0] = 1'b1; applyInputs();
    runHalf("single_left");
    chk("single_left_abs", sample_l, 1000);
    runHalf("single_right");
    chk("single_right_abs", sample_r, 1000);

    // Saturation both ways
    for (int i = 0; i < CH; i++) begin sIn[i] = 20000; en[i] = 1'b1; end
    applyInputs();
    runHalf("sat_pos_left");
    chk("sat_pos_abs", sample_l, 32767);
    runHalf("sat_pos_right");
    for (int i = 0; i < CH; i++) sIn[i] = -20000;
    applyInputs();
    runHalf("sat_neg_left");
    chk("sat_neg_abs", sample_l, -32768);

    // Volume scaling, pan and rounding toward -inf
    for (int i = 0; i < CH; i++) begin sIn[i] = 0; en[i] = 1'b0; end
    sIn[1] = -4000; en[1] = 1'b1; applyInputs();
    doCfg(1, 64, 2'b01);
    runHalf("pan_right_zero");
    chk("pan_right_abs", sample_r, 0);
    runHalf("half_vol_left");
    chk("half_vol_abs", sample_l, -2000);
    sIn[1] = 1000; applyInputs();
    doCfg(1, 255, 2'b11);
    runHalf("vol255_right");
    chk("vol255_abs", sample_r, 1992);
    sIn[1] = -1; applyInputs();
    doCfg(1, 1, 2'b11);
    runHalf("floor_left");
    chk("floor_abs", sample_l, -1);

    // Second edge 4 cycles after the first is dropped
    rightSide = lrclk;
    expVal = refMix(rightSide);
    startEdge();
    repeat (4) tick();
    lrclk = ~lrclk;
    waitResult(rightSide, "overrun_mix", expVal);
    chk("overrun_set", overrun, 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);

    // cfg writes during a mix: ch7 before its turn, ch0 after its turn
    for (int i = 0; i < CH; i++) begin sIn[i] = 500 * (i + 1) - 2000; en[i] = 1'b1; end
    applyInputs();
    doCfg(0, 100, 2'b11);
    doCfg(7, 128, 2'b11);
    rightSide = lrclk;
    mVol[7] = 0;
    expVal = refMix(rightSide);
    startEdge();
    repeat (4) tick();
    cfg_we = 1'b1; cfg_ch = 3'd7; cfg_volume = '0; cfg_pan = 2'b11;
    tick();
    cfg_ch = 3'd0; cfg_volume = 8'd200;
    tick();
    cfg_we = 1'b0;
    mVol[0] = 200;
    waitResult(rightSide, "cfg_midmix", expVal);
    runHalf("cfg_after");

    // Reset in the middle of a mix
    startEdge();
    repeat (6) tick();
    rst = 1'b1;
    lrclk = 1'b0;
    #1;
    chk("midrst_sample_l", sample_l, 0);
    chk("midrst_sample_r", sample_r, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    lPulses = 0; rPulses = 0;
    repeat (20) tick();
    chk("midrst_no_lvalid", lPulses, 0);
    chk("midrst_no_rvalid", rPulses, 0);
    for (int i = 0; i < CH; i++) begin sIn[i] = 300; en[i] = 1'b1; end
    applyInputs();
    runHalf("post_rst_unity");
    chk("post_rst_unity_abs", sample_l, 2400);

    // Randomized half-frames
    for (int n = 0; n < 24; n++) begin
      doCfg(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      doCfg(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      for (int i = 0; i < CH; i++) begin
        sIn[i] = int'($urandom_range(0, 65535)) - 32768;
        en[i]  = ($urandom_range(0, 3) != 0);
      end
      applyInputs();
      runHalf("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
